// File: rtl/wb_write_queue_pkg.sv
// wb_write_queue_pkg: shared register-file constants and the queue entry type
package wb_write_queue_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN = 32;
    localparam logic [REG_AW-1:0] REG_X0 = '0;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0] data;
    } wbq_entry_t;
endpackage

// File: rtl/wb_write_queue_match.sv
// wbq_match: pending-write lookup of one source index against the queued entries (forwarding under WBQ_FORWARD_EN)
module wbq_match
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW = $clog2(DEPTH)
) (
    input  wbq_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0]  occ,
    input  logic [PW-1:0]     head,
    input  logic [REG_AW-1:0] rs,
    output logic              hit,
    output logic [XLEN-1:0]   data
);
    // any occupied entry targeting rs marks it busy; x0 is never busy
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (occ[i] && entries[i].rd == rs && rs != REG_X0) hit = 1'b1;
    end
`ifdef WBQ_FORWARD_EN
    // walk oldest to youngest so the last match, the youngest write, wins
    always_comb begin
        data = '0;
        for (int k = 0; k < DEPTH; k++)
            if (occ[PW'(32'(head) + k)] && entries[PW'(32'(head) + k)].rd == rs && rs != REG_X0)
                data = entries[PW'(32'(head) + k)].data;
    end
`else
    logic unused_fwd;
    assign data = '0;
    // forwarding inputs are idle in this build
    always_comb begin
        unused_fwd = ^head;
        for (int i = 0; i < DEPTH; i++) unused_fwd = unused_fwd ^ (^entries[i].data);
    end
`endif
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: two-source writeback FIFO draining one write per cycle, with rs hazard flags (forwarding under WBQ_FORWARD_EN)
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = REG_AW,
    parameter int DW = XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p0_valid,
    output logic                       p0_ready,
    input  logic [AW-1:0]              p0_rd,
    input  logic [DW-1:0]              p0_data,
    input  logic                       p1_valid,
    output logic                       p1_ready,
    input  logic [AW-1:0]              p1_rd,
    input  logic [DW-1:0]              p1_data,
    output logic                       wb_we,
    output logic [AW-1:0]              wb_rd,
    output logic [DW-1:0]              wb_data,
    input  logic [AW-1:0]              rs1,
    input  logic [AW-1:0]              rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [DW-1:0]              rs1_fwd,
    output logic [DW-1:0]              rs2_fwd,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW:0] free;
    logic [DEPTH-1:0] occ;
    logic pop, p0_push, p1_push;
    logic [XLEN-1:0] m1_data, m2_data;

    // the head always drains, so its slot counts as free this cycle
    assign pop = count != '0;
    assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    assign p0_ready = rst && free >= (CW+1)'(1);
    assign p1_ready = rst && (free >= (CW+1)'(2) || (free >= (CW+1)'(1) && !(p0_valid && p0_rd != AW'(REG_X0))));
    assign p0_push = p0_valid && p0_ready && p0_rd != AW'(REG_X0);
    assign p1_push = p1_valid && p1_ready && p1_rd != AW'(REG_X0);
    assign wb_we = pop;
    assign wb_rd = pop ? AW'(mem[head].rd) : '0;
    assign wb_data = pop ? DW'(mem[head].data) : '0;

    // slot i is occupied when its distance from head is below the count
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) occ[i] = {1'b0, PW'(i) - head} < count;
    end

    // enqueue p0 before p1, drain the head every non-empty cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (p0_push) mem[tail] <= '{rd: REG_AW'(p0_rd), data: XLEN'(p0_data)};
            if (p1_push) mem[tail + PW'(p0_push)] <= '{rd: REG_AW'(p1_rd), data: XLEN'(p1_data)};
            head <= head + PW'(pop);
            tail <= tail + PW'(p0_push) + PW'(p1_push);
            count <= count + CW'(p0_push) + CW'(p1_push) - CW'(pop);
        end
    end

    wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .entries(mem), .occ(occ), .head(head), .rs(REG_AW'(rs1)), .hit(rs1_busy), .data(m1_data)
    );
    wbq_match #(.DEPTH(DEPTH)) u_match2 (
        .entries(mem), .occ(occ), .head(head), .rs(REG_AW'(rs2)), .hit(rs2_busy), .data(m2_data)
    );

    assign rs1_fwd = DW'(m1_data);
    assign rs2_fwd = DW'(m2_data);
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed self-checking bench for wb_write_queue (forwarding expectations follow WBQ_FORWARD_EN)
module tb_wb_write_queue;
    logic clk = 1'b0, rst = 1'b1;
    logic p0_valid = 1'b0, p1_valid = 1'b0;
    logic [4:0] p0_rd = '0, p1_rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] p0_data = '0, p1_data = '0;
    logic p0_ready, p1_ready, wb_we, rs1_busy, rs2_busy;
    logic [4:0] wb_rd;
    logic [31:0] wb_data, rs1_fwd, rs2_fwd;
    logic [2:0] count;
    int vectors = 0, miscompares = 0;

    wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_data(p1_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        p0_valid = v0; p0_rd = r0; p0_data = d0;
        p1_valid = v1; p1_rd = r1; p1_data = d1;
        #1;
    endtask

    task automatic wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, 64'(wb_we), 64'(we));
        chk({tag, "_rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, "_data"}, 64'(wb_data), 64'(d));
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_p0_ready", 64'(p0_ready), 64'd0);
        chk("rst_p1_ready", 64'(p1_ready), 64'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rel_p0_ready", 64'(p0_ready), 64'd1);
        chk("rel_count", 64'(count), 64'd0);

        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        chk("single_p0_ready", 64'(p0_ready), 64'd1);
        tick(); idle();
        wb("single_n1", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("single_count", 64'(count), 64'd1);
        tick();
        wb("single_n2", 1'b0, 5'd0, 32'h0);

        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        chk("dual_p0_ready", 64'(p0_ready), 64'd1);
        chk("dual_p1_ready", 64'(p1_ready), 64'd1);
        tick(); idle();
        chk("dual_count", 64'(count), 64'd2);
        wb("dual_first", 1'b1, 5'd3, 32'h11);
        tick();
        wb("dual_second", 1'b1, 5'd4, 32'h22);
        tick();
        wb("dual_empty", 1'b0, 5'd0, 32'h0);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5);
        chk("x0_p1_ready", 64'(p1_ready), 64'd1);
        tick(); idle();
        chk("x0_count", 64'(count), 64'd0);
        chk("x0_we", 64'(wb_we), 64'd0);

        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        tick();
        drive(1'b1, 5'd8, 32'h108, 1'b1, 5'd9, 32'h109);
        chk("fill_p1_ready_free3", 64'(p1_ready), 64'd1);
        tick();
        drive(1'b1, 5'd10, 32'h10A, 1'b1, 5'd11, 32'h10B);
        chk("fill_p1_ready_free2", 64'(p1_ready), 64'd1);
        tick(); idle();
        chk("full_count", 64'(count), 64'd4);
        wb("full_head", 1'b1, 5'd8, 32'h108);
        drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD);
        chk("full_p1_ready_p0_x0", 64'(p1_ready), 64'd1);
        drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
        chk("full_p0_ready", 64'(p0_ready), 64'd1);
        chk("full_p1_ready", 64'(p1_ready), 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD);
        chk("full_count_hold", 64'(count), 64'd4);
        chk("full_p1_ready_next", 64'(p1_ready), 64'd1);
        wb("full_head2", 1'b1, 5'd9, 32'h109);
        tick(); idle();
        chk("full_count_hold2", 64'(count), 64'd4);
        wb("drain_a", 1'b1, 5'd10, 32'h10A);
        tick();
        wb("drain_b", 1'b1, 5'd11, 32'h10B);
        tick();
        wb("drain_c", 1'b1, 5'd12, 32'hC);
        tick();
        wb("drain_d", 1'b1, 5'd13, 32'hD);
        tick();
        chk("drain_count", 64'(count), 64'd0);

        rs1 = 5'd7; rs2 = 5'd0;
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        chk("haz_same_cycle", 64'(rs1_busy), 64'd0);
        tick(); idle();
        chk("haz_rs1_busy", 64'(rs1_busy), 64'd1);
        chk("haz_rs2_busy_x0", 64'(rs2_busy), 64'd0);
`ifdef WBQ_FORWARD_EN
        chk("haz_rs1_fwd", 64'(rs1_fwd), 64'hB);
`else
        chk("haz_rs1_fwd", 64'(rs1_fwd), 64'h0);
`endif
        chk("haz_rs2_fwd", 64'(rs2_fwd), 64'h0);
        tick();
        rs2 = 5'd7;
        #1;
        chk("haz_rs1_busy_one", 64'(rs1_busy), 64'd1);
        chk("haz_rs2_busy_one", 64'(rs2_busy), 64'd1);
`ifdef WBQ_FORWARD_EN
        chk("haz_rs2_fwd_one", 64'(rs2_fwd), 64'hB);
`else
        chk("haz_rs2_fwd_one", 64'(rs2_fwd), 64'h0);
`endif
        tick();
        chk("haz_rs1_clear", 64'(rs1_busy), 64'd0);
        chk("haz_rs1_fwd_clear", 64'(rs1_fwd), 64'h0);

        rs1 = 5'd6;
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67);
        tick(); idle();
        chk("mid_count", 64'(count), 64'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_we", 64'(wb_we), 64'd0);
        chk("mid_rst_p0_ready", 64'(p0_ready), 64'd0);
        chk("mid_rst_busy", 64'(rs1_busy), 64'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rel_p0_ready", 64'(p0_ready), 64'd1);
        tick();
        chk("mid_rel_we", 64'(wb_we), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Producer side of the register-file write port: collects writeback results from two execution sources, ALU (p0) and load unit (p1), and drains them to the register file's single write port at one write per cycle.
- Buffers results in a small in-order FIFO.
- Reports pending-write hazards on rs1/rs2 so decode can stall.
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 5, register index width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
p0_valid  in  1  ALU result valid
p0_ready  out  1  ALU result accepted this cycle
p0_rd  in  AW  ALU destination register
p0_data  in  DW  ALU result
p1_valid  in  1  load result valid
p1_ready  out  1  load result accepted this cycle
p1_rd  in  AW  load destination register
p1_data  in  DW  load result
wb_we  out  1  register-file write enable
wb_rd  out  AW  register-file write index
wb_data  out  DW  register-file write data
rs1  in  AW  decode source index 1
rs2  in  AW  decode source index 2
rs1_busy  out  1  pending write to rs1 is queued
rs2_busy  out  1  pending write to rs2 is queued
rs1_fwd  out  DW  forwarded data for rs1 (optional feature)
rs2_fwd  out  DW  forwarded data for rs2 (optional feature)
count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, pointers 0, count=0. wb_we=0, wb_rd=0, wb_data=0, busy=0, fwd=0. Ready is low while in reset.
- Reset mid-operation discards all queued entries. Those writes are lost by design.
- Transfer on a port occurs when valid && ready.
- A transfer with rd==0 completes the handshake but is not enqueued (x0 is never written).
- Drain:
  - When count>0, head drives wb_we=1, wb_rd=head.rd, wb_data=head.data (combinational from head).
  - Head pops at the rising edge every cycle it is non-empty. The register file never stalls.
  - When empty, wb_we=0, wb_rd=0, wb_data=0.
- Latency: a result accepted in cycle N is presented on wb_* in cycle N+1 if the queue was empty. The register file writes at the end of N+1.
- Free slots this cycle: free = DEPTH - count + (count!=0), because the pop is counted.
- Readiness rules:
  - p0_ready = (free>=1).
  - p1_ready = (free>=2) || (free>=1 && !(p0_valid && p0_rd!=0)).
  - p1_ready depends combinationally on p0_valid; p0_ready never depends on p1.
- Simultaneous push: both accepted in one cycle are enqueued p0 first (older), then p1. Program order p0-before-p1 is the issue contract.
- Full with pop: when count==DEPTH, free=1, so one push is accepted in the same cycle as the pop.
- Pointers wrap modulo DEPTH. count updates as count + pushes - pop, range 0..DEPTH.
- Hazard detection:
  - rsX_busy=1 iff rsX!=0 and any occupied entry, head included, has rd==rsX.
  - Combinational over stored entries only; same-cycle inputs are not considered.
- Invariant: count never exceeds DEPTH; no push is accepted when free==0.

Optional Feature:
- Macro WBQ_FORWARD_EN.
- Defined:
  - rsX_fwd = data of the youngest occupied entry with rd==rsX.
  - Valid when rsX_busy=1; otherwise 0.
  - The youngest is selected by scanning from tail-1 back to head.
- Undefined:
  - rs1_fwd and rs2_fwd are tied to 0; no compare/mux logic is built.
  - busy behaviour is unchanged.

Decomposition:
- Shared package holds:
  - Constants REG_AW=5, XLEN=32, REG_X0=0.
  - Typedef wbq_entry_t {rd[AW], data[DW]}.
- One sub-module: wbq_match, instantiated twice (rs1, rs2). It takes the entry array, occupancy mask and index, and returns hit plus youngest data.

Test Plan:
- Reset: assert rst=0 with 2 entries queued -> count=0, wb_we=0, p0_ready=0 asynchronously; release -> p0_ready=1.
- Single push: p0 rd=5, data=0xDEADBEEF in cycle N -> cycle N+1 shows wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; cycle N+2 wb_we=0.
- Dual push on empty queue: p0 rd=3/0x11 and p1 rd=4/0x22 together -> both ready; writes appear rd=3 then rd=4 on consecutive cycles.
- x0 drop: p1 rd=0, data=0x5 -> p1_ready=1, count stays 0, wb_we never asserts.
- Full back-pressure with DEPTH=4:
  - Fill 4 entries, then both valid -> p0_ready=1 and p1_ready=0 (free=1); count stays 4.
  - Next cycle p1 is accepted and order is preserved.
- Hazard and forwarding (with WBQ_FORWARD_EN):
  - Queue rd=7/0xA then rd=7/0xB, rs1=7, rs2=0 -> rs1_busy=1, rs1_fwd=0xB, rs2_busy=0.
  - After both drain -> rs1_busy=0.
